// File: rtl/spi_master_pkg.sv
// Shared types for the SPI master engine.
//   state_e   : frame sequencer states
//   cs_active : true in the states where the selected chip select is driven low
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_e;

    function automatic logic cs_active(input state_e s);
        return (s == SETUP) || (s == XFER) || (s == HOLD);
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO without fall-through: a pushed word is visible on rd_data
// the cycle after the push. Simultaneous push and pop are allowed.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, wr_data write side; caller guarantees no push while full
//   pop, rd_data  read side; rd_data is the head word, caller pops only when not empty
//   full, empty   occupancy flags
module spi_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/spi_master_mc_core.sv
// SPI master engine with TX/RX FIFOs, CPOL/CPHA modes, MSB/LSB-first,
// 1..DATA_WIDTH-bit frames, one-hot-low chip selects and CS hold between frames.
// Ports:
//   pclk, preset                clock, synchronous active-high reset
//   cfg_*                       live configuration, latched at frame start
//   tx_data/tx_valid/tx_ready   TX FIFO push interface
//   rx_data/rx_valid/rx_ready   RX FIFO pop interface (data right-justified)
//   busy, done, rx_overrun      status; done/rx_overrun are 1-cycle pulses
//   spi_sclk/mosi/miso/cs_n     serial bus
module spi_master_mc_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NUM_CS     = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic                          cfg_en,
    input  logic                          cfg_cpol,
    input  logic                          cfg_cpha,
    input  logic                          cfg_lsb_first,
    input  logic [$clog2(DATA_WIDTH)-1:0] cfg_len,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic [$clog2(NUM_CS)-1:0]     cfg_cs_sel,
    input  logic                          cfg_cs_hold,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          rx_overrun,
    output logic                          spi_sclk,
    output logic                          spi_mosi,
    input  logic                          spi_miso,
    output logic [NUM_CS-1:0]             spi_cs_n
);

    import spi_master_pkg::*;

    localparam int unsigned LEN_W = $clog2(DATA_WIDTH);
    localparam int unsigned CS_W  = $clog2(NUM_CS);

    // Frame config lives here rather than in the package: its field widths track module parameters.
    typedef struct packed {
        logic             cpol;
        logic             cpha;
        logic             lsb_first;
        logic [LEN_W-1:0] len;
        logic [DIV_WIDTH-1:0] div;
        logic [CS_W-1:0]  cs_sel;
        logic             cs_hold;
    } spi_cfg_t;

    state_e                 state_q, state_d;
    spi_cfg_t               cfg_q;
    logic                   pend_q, pend_d;   // frame latched in HOLD, waiting out GAP for a new CS
    logic [DATA_WIDTH-1:0]  tx_sh, rx_sh, word_src;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic [LEN_W:0]         edge_cnt;
    logic                   tick, last_edge, sample_edge;
    logic                   latch, enter_setup;
    logic                   src_cpha, src_lsb;
    logic [LEN_W-1:0]       src_len;
    logic [CS_W-1:0]        src_sel;
    logic [DATA_WIDTH-1:0]  tx_head;
    logic                   tx_full, tx_empty, rx_full, rx_empty, rx_push;

    function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb,
                                     input logic [LEN_W-1:0] len);
        return lsb ? w[0] : w[len];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                        input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // LSB-first inserts at bit len so the first received bit lands at bit 0.
    function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] r,
                                                       input logic lsb,
                                                       input logic [LEN_W-1:0] len,
                                                       input logic b);
        logic [DATA_WIDTH-1:0] t;
        if (lsb) begin
            t      = r >> 1;
            t[len] = b;
        end else begin
            t = {r[DATA_WIDTH-2:0], b};
        end
        return t;
    endfunction

    assign tick        = (div_cnt == cfg_q.div);
    assign last_edge   = (edge_cnt == {cfg_q.len, 1'b1});
    assign sample_edge = (edge_cnt[0] == cfg_q.cpha);

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        latch       = 1'b0;
        enter_setup = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_en && !tx_empty) begin
                    latch       = 1'b1;
                    enter_setup = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP: if (tick) state_d = XFER;
            XFER:  if (tick && last_edge) state_d = HOLD;
            HOLD: begin
                if (tick) begin
                    if (cfg_q.cs_hold && cfg_en && !tx_empty) begin
                        latch = 1'b1;
                        if (cfg_cs_sel == cfg_q.cs_sel) begin
                            enter_setup = 1'b1;
                            state_d     = SETUP;
                        end else begin
                            pend_d  = 1'b1;
                            state_d = GAP;
                        end
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (pend_q) begin
                        pend_d      = 1'b0;
                        enter_setup = 1'b1;
                        state_d     = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Values of the frame about to start: live inputs when latching this cycle, else latched copy.
    assign word_src = latch ? tx_head       : tx_sh;
    assign src_cpha = latch ? cfg_cpha      : cfg_q.cpha;
    assign src_lsb  = latch ? cfg_lsb_first : cfg_q.lsb_first;
    assign src_len  = latch ? cfg_len       : cfg_q.len;
    assign src_sel  = latch ? cfg_cs_sel    : cfg_q.cs_sel;

    assign rx_push = (state_q == HOLD) && tick && !rx_full;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            cfg_q      <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_cs_n   <= '1;
            done       <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            done       <= 1'b0;
            rx_overrun <= 1'b0;
            div_cnt    <= (state_q == IDLE || tick) ? '0 : div_cnt + 1'b1;
            spi_cs_n   <= cs_active(state_d) ? ~(NUM_CS'(1) << src_sel) : '1;

            if (latch) begin
                cfg_q <= '{cpol: cfg_cpol, cpha: cfg_cpha, lsb_first: cfg_lsb_first,
                           len: cfg_len, div: cfg_div, cs_sel: cfg_cs_sel,
                           cs_hold: cfg_cs_hold};
                tx_sh <= tx_head;
            end

            case (state_q)
                IDLE:    spi_sclk <= cfg_cpol;
                XFER:    if (tick) spi_sclk <= ~spi_sclk;
                default: spi_sclk <= cfg_q.cpol;
            endcase

            if (state_q == XFER && tick) begin
                edge_cnt <= edge_cnt + 1'b1;
                if (sample_edge) begin
                    rx_sh <= rx_shift(rx_sh, cfg_q.lsb_first, cfg_q.len, spi_miso);
                end else if (!last_edge) begin
                    spi_mosi <= out_bit(tx_sh, cfg_q.lsb_first, cfg_q.len);
                    tx_sh    <= shift_out(tx_sh, cfg_q.lsb_first);
                end
            end

            if (state_q == HOLD && tick) begin
                done       <= 1'b1;
                rx_overrun <= rx_full;
            end

            // CPHA=0 presents the first bit before the first edge; overrides the latch load above.
            if (enter_setup) begin
                edge_cnt <= '0;
                rx_sh    <= '0;
                if (!src_cpha) begin
                    spi_mosi <= out_bit(word_src, src_lsb, src_len);
                    tx_sh    <= shift_out(word_src, src_lsb);
                end
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;

    spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (pclk),
        .rst     (preset),
        .push    (tx_valid && !tx_full),
        .wr_data (tx_data),
        .pop     (latch),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (pclk),
        .rst     (preset),
        .push    (rx_push),
        .wr_data (rx_sh),
        .pop     (rx_ready && !rx_empty),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty)
    );

endmodule

// File: tb/tb_spi_master_mc_core.sv
// Self-checking bench for spi_master_mc_core with MISO looped back to MOSI.
// Stimulus pushes expected RX words into a scoreboard queue; a negedge monitor
// pops and compares whenever the DUT RX FIFO is popped.
module tb_spi_master_mc_core;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cfg_en, cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_cs_hold;
    logic [4:0]  cfg_len;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_cs_sel;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, rx_ready;
    logic        busy, done, rx_overrun;
    logic        spi_sclk, spi_mosi, spi_miso;
    logic [3:0]  spi_cs_n;

    assign spi_miso = spi_mosi;

    spi_master_mc_core #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .NUM_CS(4), .DIV_WIDTH(16)) dut (
        .pclk(pclk), .preset(preset), .cfg_en(cfg_en), .cfg_cpol(cfg_cpol),
        .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first), .cfg_len(cfg_len),
        .cfg_div(cfg_div), .cfg_cs_sel(cfg_cs_sel), .cfg_cs_hold(cfg_cs_hold),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .rx_overrun(rx_overrun),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n)
    );

    always #5 pclk = ~pclk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          ovr_cnt = 0;
    int          rise_q[$];
    logic [63:0] mosi_cap = '0;
    int          mosi_n = 0;
    logic        prev_sclk = 1'b0;
    logic [31:0] exp_q[$];
    logic        mode_cpol = 1'b0;
    logic        mode_cpha = 1'b0;
    logic        hold_watch = 1'b0;
    int          hold_target = 0;
    int          cs_low_seen = 0;
    int          cs_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: edge/bit capture, pulse counting and scoreboard pops.
    always @(negedge pclk) begin
        cyc++;
        if (done) done_cnt++;
        if (rx_overrun) ovr_cnt++;
        if (busy && spi_sclk !== prev_sclk) begin
            if (spi_sclk) rise_q.push_back(cyc);
            if (spi_sclk == (mode_cpol ^ ~mode_cpha)) begin
                mosi_cap = {mosi_cap[62:0], spi_mosi};
                mosi_n++;
            end
        end
        prev_sclk = spi_sclk;
        if (hold_watch && spi_cs_n != 4'b1111) cs_low_seen++;
        if (hold_watch && cs_low_seen > 0 && done_cnt < hold_target && spi_cs_n != 4'b1011)
            cs_bad++;
        if (!preset && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got 0x%0h required no word", rx_data);
            end else begin
                check("rx_data", {32'h0, rx_data}, {32'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic push_word(input logic [31:0] d, input logic [31:0] e, input bit want);
        int k = 0;
        @(negedge pclk);
        while (!tx_ready && k < 2000) begin
            @(negedge pclk);
            k++;
        end
        if (!tx_ready) begin
            check("push_timeout", 64'(tx_ready), 64'd1);
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            if (want) exp_q.push_back(e);
            @(negedge pclk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int k = 0;
        while (done_cnt < target && k < 20000) begin
            @(negedge pclk);
            k++;
        end
        check(name, 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 5000) begin
            @(negedge pclk);
            k++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic set_cfg(input logic cpol, input logic cpha, input logic lsb,
                           input logic [4:0] len, input logic [15:0] div,
                           input logic [1:0] sel, input logic hold);
        cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
        cfg_len = len; cfg_div = div; cfg_cs_sel = sel; cfg_cs_hold = hold;
        mode_cpol = cpol; mode_cpha = cpha;
    endtask

    initial begin
        int d0, r0, n0, o0, k, bad;
        logic [31:0] rev;
        cfg_en = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b1;
        set_cfg(1'b0, 1'b0, 1'b0, 5'd7, 16'd1, 2'd0, 1'b0);

        // Reset state
        repeat (3) @(posedge pclk);
        #1;
        check("rst_sclk",   64'(spi_sclk),   64'd0);
        check("rst_mosi",   64'(spi_mosi),   64'd0);
        check("rst_cs_n",   64'(spi_cs_n),   64'hF);
        check("rst_busy",   64'(busy),       64'd0);
        check("rst_done",   64'(done),       64'd0);
        check("rst_ovr",    64'(rx_overrun), 64'd0);
        check("rst_txrdy",  64'(tx_ready),   64'd1);
        check("rst_rxval",  64'(rx_valid),   64'd0);
        @(negedge pclk);
        preset = 1'b0;
        repeat (2) @(negedge pclk);

        // Mode 0, len=7, div=1, 0xA5
        d0 = done_cnt; r0 = rise_q.size();
        push_word(32'hA5, 32'h000000A5, 1'b1);
        k = 0;
        while (spi_cs_n == 4'hF && k < 10) begin
            @(negedge pclk);
            k++;
        end
        check("cs_latency_le3", 64'(k <= 3), 64'd1);
        check("cs_sel0", 64'(spi_cs_n), 64'hE);
        wait_done(d0 + 1, "m0_done_wait");
        repeat (4) @(negedge pclk);
        check("m0_done_count", 64'(done_cnt - d0), 64'd1);
        check("m0_sclk_rises", 64'(rise_q.size() - r0), 64'd8);
        bad = 0;
        for (int i = r0 + 1; i < rise_q.size(); i++)
            if (rise_q[i] - rise_q[i-1] != 4) bad++;
        check("m0_sclk_period", 64'(bad), 64'd0);
        wait_drain("m0_rx_drain");

        // Mode 3, len=31, LSB-first, 0xDEADBEEF
        set_cfg(1'b1, 1'b1, 1'b1, 5'd31, 16'd0, 2'd0, 1'b0);
        repeat (3) @(negedge pclk);
        check("m3_idle_sclk", 64'(spi_sclk), 64'd1);
        d0 = done_cnt; n0 = mosi_n;
        push_word(32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        wait_done(d0 + 1, "m3_done_wait");
        check("m3_mosi_bits", 64'(mosi_n - n0), 64'd32);
        check("m3_first_bit", 64'(mosi_cap[31]), 64'd1);
        for (int i = 0; i < 32; i++) rev[i] = mosi_cap[31 - i];
        check("m3_mosi_word", 64'(rev), 64'hDEADBEEF);
        wait_drain("m3_rx_drain");

        // len=11, MSB-first, 0xFABC -> 0xABC on the wire
        set_cfg(1'b0, 1'b0, 1'b0, 5'd11, 16'd1, 2'd0, 1'b0);
        repeat (3) @(negedge pclk);
        d0 = done_cnt; n0 = mosi_n;
        push_word(32'h0000FABC, 32'h00000ABC, 1'b1);
        wait_done(d0 + 1, "l11_done_wait");
        check("l11_mosi_bits", 64'(mosi_n - n0), 64'd12);
        check("l11_mosi_word", 64'(mosi_cap[11:0]), 64'hABC);
        wait_drain("l11_rx_drain");

        // CS hold across 4 frames on cs_sel=2
        set_cfg(1'b0, 1'b0, 1'b0, 5'd7, 16'd0, 2'd2, 1'b1);
        repeat (3) @(negedge pclk);
        d0 = done_cnt;
        hold_target = d0 + 4;
        hold_watch = 1'b1;
        push_word(32'h11, 32'h11, 1'b1);
        push_word(32'h22, 32'h22, 1'b1);
        push_word(32'h33, 32'h33, 1'b1);
        push_word(32'h44, 32'h44, 1'b1);
        wait_done(d0 + 4, "hold_done_wait");
        hold_watch = 1'b0;
        check("hold_cs_seen", 64'(cs_low_seen > 0), 64'd1);
        check("hold_cs_steady", 64'(cs_bad), 64'd0);
        repeat (3) @(negedge pclk);
        check("hold_cs_release", 64'(spi_cs_n), 64'hF);
        wait_drain("hold_rx_drain");

        // RX overrun: 5 frames with rx_ready low
        set_cfg(1'b0, 1'b0, 1'b0, 5'd7, 16'd0, 2'd0, 1'b0);
        rx_ready = 1'b0;
        repeat (2) @(negedge pclk);
        d0 = done_cnt; o0 = ovr_cnt;
        push_word(32'h01, 32'h01, 1'b1);
        push_word(32'h02, 32'h02, 1'b1);
        push_word(32'h03, 32'h03, 1'b1);
        push_word(32'h04, 32'h04, 1'b1);
        push_word(32'h05, 32'h05, 1'b0);
        wait_done(d0 + 5, "ovr_done_wait");
        repeat (3) @(negedge pclk);
        check("ovr_pulses", 64'(ovr_cnt - o0), 64'd1);
        check("ovr_rx_valid", 64'(rx_valid), 64'd1);
        rx_ready = 1'b1;
        wait_drain("ovr_rx_drain");
        repeat (2) @(negedge pclk);
        check("ovr_rx_empty", 64'(rx_valid), 64'd0);

        // Reset mid-XFER, then a normal frame
        set_cfg(1'b0, 1'b0, 1'b0, 5'd7, 16'd3, 2'd1, 1'b0);
        repeat (2) @(negedge pclk);
        n0 = mosi_n;
        push_word(32'hFF, 32'hFF, 1'b0);
        k = 0;
        while (mosi_n < n0 + 3 && k < 500) begin
            @(negedge pclk);
            k++;
        end
        check("rst_mid_reached", 64'(mosi_n >= n0 + 3), 64'd1);
        preset = 1'b1;
        @(posedge pclk);
        #1;
        check("rstm_cs_n",  64'(spi_cs_n), 64'hF);
        check("rstm_sclk",  64'(spi_sclk), 64'd0);
        check("rstm_busy",  64'(busy),     64'd0);
        check("rstm_rxval", 64'(rx_valid), 64'd0);
        d0 = done_cnt;
        @(negedge pclk);
        preset = 1'b0;
        repeat (60) @(negedge pclk);
        check("rstm_no_done", 64'(done_cnt - d0), 64'd0);
        push_word(32'h3C, 32'h3C, 1'b1);
        wait_done(d0 + 1, "rstm_done_wait");
        wait_drain("rstm_rx_drain");

        repeat (5) @(negedge pclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
